// File: rtl/acc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// acc_ctrl_pkg
// Shared definitions for the adder-tree accumulator controller:
//   state_t    controller FSM states (IDLE, RUN, DRAIN, DONE)
//   TREE_IDIM  number of adder-tree inputs (3x3 window taps)
//   TREE_BDEP  adder-tree register depth, also the default controller TLAT
//   TREE_OWID  width of the tree sum (0..9 needs 4 bits)
//   popcnt3    helper used by the tree's first stage
// ---------------------------------------------------------------------------
package acc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int TREE_IDIM = 9;
  localparam int TREE_BDEP = 2;
  localparam int TREE_OWID = 4;
  localparam int DEF_TLAT  = TREE_BDEP;

  // Count of ones in a 3-bit group (0..3).
  function automatic logic [1:0] popcnt3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/AdderTree9_1.sv
// ---------------------------------------------------------------------------
// AdderTree9_1
// Pipelined unary adder tree: 9 one-bit inputs -> 4-bit count, 2 register
// stages (IDIM=9, IWID=1, BDEP=2). Stage 1 counts three 3-bit groups,
// stage 2 adds the three partial counts.
// Ports:
//   i_clk    in  1   clock
//   i_rst_n  in  1   asynchronous active-low reset
//   i_data   in  9   one bit per window tap
//   o_sum    out 4   number of set bits, two cycles after i_data
// ---------------------------------------------------------------------------
module AdderTree9_1
  import acc_ctrl_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [TREE_IDIM-1:0] i_data,
  output logic [TREE_OWID-1:0] o_sum
);

  logic [1:0] r_part0;
  logic [1:0] r_part1;
  logic [1:0] r_part2;

  // Two-stage reduction: group counts, then their sum.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_part0 <= 2'b0;
      r_part1 <= 2'b0;
      r_part2 <= 2'b0;
      o_sum   <= {TREE_OWID{1'b0}};
    end else begin
      r_part0 <= popcnt3(i_data[2:0]);
      r_part1 <= popcnt3(i_data[5:3]);
      r_part2 <= popcnt3(i_data[8:6]);
      o_sum   <= {2'b00, r_part0} + {2'b00, r_part1} + {2'b00, r_part2};
    end
  end

endmodule

// File: rtl/adder_tree_acc_ctrl.sv
// ---------------------------------------------------------------------------
// adder_tree_acc_ctrl
// Sequences a 9-input adder tree over a window of i_len beats, accumulates
// the per-beat counts and returns one total per window on a valid/ready port.
// Optional build macro: ACC_SAT_EN -- accumulator saturates at all-ones on
// overflow instead of wrapping (o_out_ovf reports the overflow either way).
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_start, i_len         window start (taken only in IDLE) and beat count
//   o_busy                 high in every state except IDLE
//   i_in_valid, o_in_ready, i_in_data   beat input handshake, 9-bit taps
//   o_out_valid, i_out_ready            result handshake
//   o_out_sum, o_out_ovf                window total and overflow flag
// ---------------------------------------------------------------------------
module adder_tree_acc_ctrl
  import acc_ctrl_pkg::*;
#(
  parameter int LWID = 8,
  parameter int AWID = 12,
  parameter int TLAT = DEF_TLAT   // must equal the tree's register depth
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [LWID-1:0]      i_len,
  output logic                 o_busy,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [TREE_IDIM-1:0] i_in_data,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [AWID-1:0]      o_out_sum,
  output logic                 o_out_ovf
);

  // Oldest slot of the valid pipe: lines up with the tree output.
  localparam logic [TLAT-1:0] VP_OLDEST = TLAT'(1'b1) << (TLAT - 1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [LWID-1:0]        r_rem_cnt;
  logic [TLAT-1:0]        r_vpipe;
  logic [AWID-1:0]        r_acc;
  logic [AWID-1:0]        w_acc_next;
  logic                   r_ovf;
  logic                   w_ovf_next;
  logic [AWID:0]          w_add;
  logic                   w_accept;
  logic                   w_start_acc;
  logic                   w_last_beat;
  logic                   w_drained;
  logic                   w_tree_hit;
  logic                   w_rst_n;
  logic [TREE_IDIM-1:0]   w_tree_in;
  logic [TREE_OWID-1:0]   w_tree_sum;

  assign w_rst_n     = ~i_rst;
  assign w_accept    = i_in_valid & o_in_ready;
  assign w_start_acc = (r_state == ST_IDLE) & i_start;
  assign w_last_beat = w_accept & (r_rem_cnt == LWID'(1));
  assign w_tree_hit  = r_vpipe[TLAT-1];
  // Nothing left in flight once the oldest slot has been consumed.
  assign w_drained   = (r_vpipe & ~VP_OLDEST) == {TLAT{1'b0}};
  // Idle cycles push zeros so stale data never reaches the accumulator.
  assign w_tree_in   = w_accept ? i_in_data : {TREE_IDIM{1'b0}};
  assign w_add       = {1'b0, r_acc} + {{(AWID + 1 - TREE_OWID){1'b0}}, w_tree_sum};

  AdderTree9_1 u_tree (
    .i_clk   (i_clk),
    .i_rst_n (w_rst_n),
    .i_data  (w_tree_in),
    .o_sum   (w_tree_sum)
  );

  // Next-state logic of the window sequencer.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_next = (i_len == LWID'(0)) ? ST_DONE : ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last_beat) w_state_next = ST_DRAIN;
        else             w_state_next = ST_RUN;
      end
      ST_DRAIN: begin
        if (w_drained) w_state_next = ST_DONE;
        else           w_state_next = ST_DRAIN;
      end
      ST_DONE: begin
        if (i_out_ready) w_state_next = ST_IDLE;
        else             w_state_next = ST_DONE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Accumulator update: clear on start, add the tree sum when it is valid.
  always_comb begin
    w_acc_next = r_acc;
    w_ovf_next = r_ovf;
    if (w_start_acc) begin
      w_acc_next = {AWID{1'b0}};
      w_ovf_next = 1'b0;
    end else if (w_tree_hit) begin
      w_ovf_next = r_ovf | w_add[AWID];
`ifdef ACC_SAT_EN
      // Once overflowed, stay pinned at the maximum for the rest of the window.
      if (r_ovf | w_add[AWID]) w_acc_next = {AWID{1'b1}};
      else                     w_acc_next = w_add[AWID-1:0];
`else
      w_acc_next = w_add[AWID-1:0];
`endif
    end else begin
      w_acc_next = r_acc;
      w_ovf_next = r_ovf;
    end
  end

  // Controller state: FSM, beat counter, valid pipe, accumulator.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_rem_cnt <= {LWID{1'b0}};
      r_vpipe   <= {TLAT{1'b0}};
      r_acc     <= {AWID{1'b0}};
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_vpipe <= (r_vpipe << 1) | TLAT'(w_accept);
      r_acc   <= w_acc_next;
      r_ovf   <= w_ovf_next;
      if (w_start_acc)   r_rem_cnt <= i_len;
      else if (w_accept) r_rem_cnt <= r_rem_cnt - LWID'(1);
      else               r_rem_cnt <= r_rem_cnt;
    end
  end

  // Registered outputs decoded from the next state; the result is captured
  // on entry to DONE and held until the handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_busy      <= 1'b0;
      o_in_ready  <= 1'b0;
      o_out_valid <= 1'b0;
      o_out_sum   <= {AWID{1'b0}};
      o_out_ovf   <= 1'b0;
    end else begin
      o_busy      <= (w_state_next != ST_IDLE);
      o_in_ready  <= (w_state_next == ST_RUN);
      o_out_valid <= (w_state_next == ST_DONE);
      if (w_state_next == ST_DONE) begin
        if (r_state != ST_DONE) begin
          o_out_sum <= w_acc_next;
          o_out_ovf <= w_ovf_next;
        end else begin
          o_out_sum <= o_out_sum;
          o_out_ovf <= o_out_ovf;
        end
      end else begin
        o_out_sum <= {AWID{1'b0}};
        o_out_ovf <= 1'b0;
      end
    end
  end

endmodule
